// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine sequencer.
//   - coin-type encodings and coin values (1/5/10)
//   - FSM state constants (IDLE/VEND/CHANGE)
//   - credit width and the item price lookup helper
package vend_pkg;

    localparam int CW = 5;

    localparam logic [1:0] COIN_1   = 2'b00;
    localparam logic [1:0] COIN_5   = 2'b01;
    localparam logic [1:0] COIN_10  = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam logic [CW-1:0] VAL_1  = 5'd1;
    localparam logic [CW-1:0] VAL_5  = 5'd5;
    localparam logic [CW-1:0] VAL_10 = 5'd10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    // Value of an encoded coin; the invalid code maps to 0.
    function automatic logic [CW-1:0] coin_value(input logic [1:0] t);
        case (t)
            COIN_1:  return VAL_1;
            COIN_5:  return VAL_5;
            COIN_10: return VAL_10;
            default: return '0;
        endcase
    endfunction

    // Price table is packed item3..item0, CW bits per item.
    function automatic logic [CW-1:0] item_price(input logic [1:0] item,
                                                 input logic [4*CW-1:0] tbl);
        return tbl[item*CW +: CW];
    endfunction

endpackage

// File: rtl/vend_chg_disp.sv
// Change dispenser: greedy 10/5/1 coin selection over a valid/ready handshake.
// Purely combinational; the owning FSM holds the credit register.
// Ports:
//   active      in  1   FSM is in CHANGE
//   credit      in  CW  remaining change
//   chg_ready   in  1   dispenser accepts offered coin
//   chg_valid   out 1   coin offered
//   chg_type    out 2   offered coin encoding
//   take        out 1   handshake completes this cycle
//   credit_next out CW  credit after removing the offered coin
//   done        out 1   handshake empties the credit
module vend_chg_disp
    import vend_pkg::*;
(
    input  logic          active,
    input  logic [CW-1:0] credit,
    input  logic          chg_ready,
    output logic          chg_valid,
    output logic [1:0]    chg_type,
    output logic          take,
    output logic [CW-1:0] credit_next,
    output logic          done
);

    // Type depends only on credit, which only moves on a handshake,
    // so the offer stays stable while the dispenser stalls.
    always_comb begin
        chg_type = COIN_1;
        if (credit >= VAL_10)     chg_type = COIN_10;
        else if (credit >= VAL_5) chg_type = COIN_5;
    end

    assign chg_valid   = active;
    assign take        = active && chg_ready;
    assign credit_next = credit - coin_value(chg_type);
    assign done        = take && (credit_next == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine sequencer top: coin accumulation, price check, vend strobe,
// then greedy change return through vend_chg_disp.
// Optional feature: define VEND_TIMEOUT_EN for auto-refund after
// TIMEOUT_CYCLES idle cycles with credit held.
// Ports:
//   clk_i, rst_i (async, active-high)
//   coin_valid_i/coin_type_i -> coin_reject_o
//   sel_valid_i/sel_item_i, cancel_i -> deny_o, vend_o, vend_item_o
//   chg_valid_o/chg_type_o <- chg_ready_i
//   credit_o, busy_o
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT     = 31,
    parameter int PRICE0         = 7,
    parameter int PRICE1         = 12,
    parameter int PRICE2         = 15,
    parameter int PRICE3         = 20,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          coin_valid_i,
    input  logic [1:0]    coin_type_i,
    output logic          coin_reject_o,
    input  logic          sel_valid_i,
    input  logic [1:0]    sel_item_i,
    input  logic          cancel_i,
    output logic          deny_o,
    output logic          vend_o,
    output logic [1:0]    vend_item_o,
    output logic          chg_valid_o,
    output logic [1:0]    chg_type_o,
    input  logic          chg_ready_i,
    output logic [CW-1:0] credit_o,
    output logic          busy_o
);

    localparam logic [4*CW-1:0] PRICES = {CW'(PRICE3), CW'(PRICE2), CW'(PRICE1), CW'(PRICE0)};

    logic [1:0]    state;
    logic [CW-1:0] credit;
    logic          take, done;
    logic [CW-1:0] credit_dec;

    vend_chg_disp u_disp (
        .active      (state == ST_CHANGE),
        .credit      (credit),
        .chg_ready   (chg_ready_i),
        .chg_valid   (chg_valid_o),
        .chg_type    (chg_type_o),
        .take        (take),
        .credit_next (credit_dec),
        .done        (done)
    );

    // A cancel with nothing to refund is not an event, so it does not
    // block a select or coin in the same cycle.
    logic          cancel_ev;
    logic [CW-1:0] price;
    logic          sel_ok;
    logic [CW:0]   coin_sum;
    logic          coin_ok;
    logic          timeout_go;

    assign cancel_ev = cancel_i && (credit != '0);
    assign price     = item_price(sel_item_i, PRICES);
    assign sel_ok    = credit >= price;
    // One bit wider so an overflowing sum is seen rather than wrapped.
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_value(coin_type_i)};
    assign coin_ok   = (coin_type_i != COIN_BAD) && (coin_sum <= (CW+1)'(MAX_CREDIT));

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          idle_ev;

    assign idle_ev    = cancel_ev || sel_valid_i || coin_valid_i;
    assign timeout_go = (state == ST_IDLE) && (credit != '0) && !idle_ev
                        && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            to_cnt <= '0;
        else if (state != ST_IDLE || credit == '0 || idle_ev || timeout_go)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_go     = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            credit        <= '0;
            coin_reject_o <= 1'b0;
            deny_o        <= 1'b0;
            vend_o        <= 1'b0;
            vend_item_o   <= '0;
        end else begin
            coin_reject_o <= 1'b0;
            deny_o        <= 1'b0;
            vend_o        <= 1'b0;
            vend_item_o   <= '0;
            case (state)
                ST_IDLE: begin
                    if (cancel_ev) begin
                        state         <= ST_CHANGE;
                        coin_reject_o <= coin_valid_i;
                    end else if (sel_valid_i) begin
                        coin_reject_o <= coin_valid_i;
                        if (sel_ok) begin
                            credit      <= credit - price;
                            state       <= ST_VEND;
                            vend_o      <= 1'b1;
                            vend_item_o <= sel_item_i;
                        end else begin
                            deny_o <= 1'b1;
                        end
                    end else if (coin_valid_i) begin
                        if (coin_ok) credit        <= coin_sum[CW-1:0];
                        else         coin_reject_o <= 1'b1;
                    end else if (timeout_go) begin
                        state <= ST_CHANGE;
                    end
                end
                ST_VEND: begin
                    coin_reject_o <= coin_valid_i;
                    state         <= (credit != '0) ? ST_CHANGE : ST_IDLE;
                end
                ST_CHANGE: begin
                    coin_reject_o <= coin_valid_i;
                    if (take) credit <= credit_dec;
                    if (done) state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign credit_o = credit;
    assign busy_o   = (state == ST_VEND) || (state == ST_CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       coin_valid_i;
    logic [1:0] coin_type_i;
    logic       coin_reject_o;
    logic       sel_valid_i;
    logic [1:0] sel_item_i;
    logic       cancel_i;
    logic       deny_o;
    logic       vend_o;
    logic [1:0] vend_item_o;
    logic       chg_valid_o;
    logic [1:0] chg_type_o;
    logic       chg_ready_i;
    logic [4:0] credit_o;
    logic       busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    vend_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .coin_valid_i(coin_valid_i), .coin_type_i(coin_type_i), .coin_reject_o(coin_reject_o),
        .sel_valid_i(sel_valid_i), .sel_item_i(sel_item_i), .cancel_i(cancel_i),
        .deny_o(deny_o), .vend_o(vend_o), .vend_item_o(vend_item_o),
        .chg_valid_o(chg_valid_o), .chg_type_o(chg_type_o), .chg_ready_i(chg_ready_i),
        .credit_o(credit_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic insert(input logic [1:0] t);
        coin_valid_i = 1'b1;
        coin_type_i  = t;
        tick();
        coin_valid_i = 1'b0;
    endtask

    task automatic select(input logic [1:0] item);
        sel_valid_i = 1'b1;
        sel_item_i  = item;
        tick();
        sel_valid_i = 1'b0;
    endtask

    task automatic cancel;
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
    endtask

    task automatic take(input string tag, input logic [1:0] typ, input logic [4:0] after);
        chk({tag, ".valid"}, chg_valid_o, 1);
        chk({tag, ".type"}, chg_type_o, typ);
        chg_ready_i = 1'b1;
        tick();
        chg_ready_i = 1'b0;
        chk({tag, ".credit"}, credit_o, after);
    endtask

    initial begin
        rst_i = 1'b1; coin_valid_i = 0; coin_type_i = 0; sel_valid_i = 0;
        sel_item_i = 0; cancel_i = 0; chg_ready_i = 0;
        repeat (2) tick();
        chk("rst.credit", credit_o, 0);
        chk("rst.busy", busy_o, 0);
        chk("rst.chg_valid", chg_valid_o, 0);
        chk("rst.vend", vend_o, 0);
        rst_i = 1'b0;
        tick();

        // 10+5, buy item1 (12): vend, then change 1,1,1
        insert(2'b10); insert(2'b01);
        chk("t1.credit15", credit_o, 15);
        select(2'd1);
        chk("t1.vend", vend_o, 1);
        chk("t1.item", vend_item_o, 1);
        chk("t1.credit3", credit_o, 3);
        chk("t1.busy", busy_o, 1);
        tick();
        chk("t1.vend_off", vend_o, 0);
        chk("t1.item_off", vend_item_o, 0);
        take("t1.c0", 2'b00, 2);
        take("t1.c1", 2'b00, 1);
        take("t1.c2", 2'b00, 0);
        chk("t1.idle_valid", chg_valid_o, 0);
        chk("t1.idle_busy", busy_o, 0);

        // credit 5, item0 (7) denied
        insert(2'b01);
        select(2'd0);
        chk("t2.deny", deny_o, 1);
        chk("t2.novend", vend_o, 0);
        chk("t2.credit", credit_o, 5);
        tick();
        chk("t2.deny_pulse", deny_o, 0);
        chk("t2.busy", busy_o, 0);

        // 25 + 10 overflows -> reject; then +5 -> 30
        insert(2'b10); insert(2'b10);
        chk("t3.credit25", credit_o, 25);
        insert(2'b10);
        chk("t3.reject", coin_reject_o, 1);
        chk("t3.credit_kept", credit_o, 25);
        tick();
        chk("t3.reject_pulse", coin_reject_o, 0);
        insert(2'b01);
        chk("t3.credit30", credit_o, 30);
        chk("t3.no_reject", coin_reject_o, 0);
        cancel();
        take("t3.c0", 2'b10, 20);
        take("t3.c1", 2'b10, 10);
        take("t3.c2", 2'b10, 0);
        chk("t3.idle", busy_o, 0);

        // exact price: 15 buys item2, straight back to IDLE
        insert(2'b10); insert(2'b01);
        select(2'd2);
        chk("t4.vend", vend_o, 1);
        chk("t4.item", vend_item_o, 2);
        chk("t4.credit", credit_o, 0);
        tick();
        chk("t4.busy", busy_o, 0);
        chk("t4.no_change", chg_valid_o, 0);

        // invalid coin; select+coin same cycle (select wins, coin rejected)
        insert(2'b11);
        chk("t5.bad_reject", coin_reject_o, 1);
        chk("t5.bad_credit", credit_o, 0);
        coin_valid_i = 1'b1; coin_type_i = 2'b01;
        select(2'd0);
        coin_valid_i = 1'b0;
        chk("t5.pri_deny", deny_o, 1);
        chk("t5.pri_reject", coin_reject_o, 1);
        chk("t5.pri_credit", credit_o, 0);

        // 17, cancel, dispenser stalls 3 cycles; coin during CHANGE rejected
        insert(2'b10); insert(2'b01); insert(2'b00); insert(2'b00);
        chk("t6.credit17", credit_o, 17);
        cancel();
        for (int i = 0; i < 3; i++) begin
            chk("t6.stall_valid", chg_valid_o, 1);
            chk("t6.stall_type", chg_type_o, 2'b10);
            chk("t6.stall_credit", credit_o, 17);
            if (i == 1) insert(2'b01); else tick();
            if (i == 1) chk("t6.busy_reject", coin_reject_o, 1);
        end
        take("t6.c0", 2'b10, 7);
        take("t6.c1", 2'b01, 2);
        take("t6.c2", 2'b00, 1);
        take("t6.c3", 2'b00, 0);
        chk("t6.idle", chg_valid_o, 0);

        // async reset while returning 6
        insert(2'b01); insert(2'b00);
        cancel();
        chk("t7.in_change", chg_valid_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("t7.rst_valid", chg_valid_o, 0);
        chk("t7.rst_credit", credit_o, 0);
        chk("t7.rst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        insert(2'b01);
        chk("t7.coin_after", credit_o, 5);
        chk("t7.coin_ok", coin_reject_o, 0);

        // idle with credit 5
`ifdef VEND_TIMEOUT_EN
        repeat (7) tick();
        chk("t8.pre_timeout", chg_valid_o, 0);
        chk("t8.pre_credit", credit_o, 5);
        tick();
        take("t8.refund", 2'b01, 0);
        chk("t8.idle", busy_o, 0);
`else
        repeat (20) tick();
        chk("t8.held_credit", credit_o, 5);
        chk("t8.no_refund", chg_valid_o, 0);
        chk("t8.idle", busy_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
